fsm_calibration: RTL and testbench

Calibration sequencer for the synchronization block. While start_signal is held high, it waits for each fast-gate opto window, then for a phase-reference edge. It then fires one trigger pulse delayed from that edge by a phase shift that grows by one step per shot, sweeping the trigger across the phase period. It sits between the board-level opto/phase inputs (asynchronous) and the detector trigger output.

---
 rtl/fsm_calibration_pkg.sv | 26 ++
 rtl/fsm_calibration_sync_edge.sv | 29 ++
 rtl/fsm_calibration.sv | 135 +++++++++++++
 tb/tb_fsm_calibration.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_calibration_pkg.sv
// Shared types and default timing for the calibration sequencer.
// Defaults assume a 400 MHz clock.
package fsm_calibration_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FG,
    FG_WAIT,
    WAIT_PH,
    SHIFT,
    FIRE,
    NEXT
  } state_t;

  localparam int unsigned DEF_FG_DELAY_CYCLES   = 800000;
  localparam int unsigned DEF_PHASE_STEP_CYCLES = 8;
  localparam int unsigned DEF_PHASE_STEPS       = 60;
  localparam int unsigned DEF_PULSE_CYCLES      = 40;
  localparam int unsigned DEF_SYNC_STAGES       = 2;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fsm_calibration_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input.
// Provides the synchronized level and a one-clock rising-edge pulse.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic                   prev_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], async_in};
      prev_reg  <= stage_reg[SYNC_STAGES-1];
    end
  end

  assign level = stage_reg[SYNC_STAGES-1];
  assign rise  = stage_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/fsm_calibration.sv
// Calibration sequencer: per fast-gate cycle, waits out the gate delay, locks to
// a phase edge and fires one trigger whose delay from that edge sweeps per shot.
module fsm_calibration
  import fsm_calibration_pkg::*;
#(
  parameter int unsigned FG_DELAY_CYCLES   = DEF_FG_DELAY_CYCLES,
  parameter int unsigned PHASE_STEP_CYCLES = DEF_PHASE_STEP_CYCLES,
  parameter int unsigned PHASE_STEPS       = DEF_PHASE_STEPS,
  parameter int unsigned PULSE_CYCLES      = DEF_PULSE_CYCLES,
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic start_signal,
  input  logic fg_signal,
  input  logic phase_signal,
  output logic output_trigger
);

  localparam int unsigned MAX_SHIFT = (PHASE_STEPS - 1) * PHASE_STEP_CYCLES;
  localparam int unsigned CNT_MAX0  = (FG_DELAY_CYCLES > PULSE_CYCLES) ? FG_DELAY_CYCLES : PULSE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX0 > MAX_SHIFT) ? CNT_MAX0 : MAX_SHIFT;
  localparam int unsigned CNT_W     = width_for(CNT_MAX);
  localparam int unsigned SHIFT_W   = width_for(MAX_SHIFT);
  localparam int unsigned STEP_W    = width_for(PHASE_STEPS - 1);

  localparam logic [CNT_W-1:0]  FG_LAST    = CNT_W'(FG_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(PHASE_STEPS - 1);

  logic start_sync, start_rise_unused;
  logic fg_level_unused, fg_rise;
  logic phase_level_unused, phase_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clock(clock), .reset(reset), .async_in(start_signal),
    .level(start_sync), .rise(start_rise_unused)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fg (
    .clock(clock), .reset(reset), .async_in(fg_signal),
    .level(fg_level_unused), .rise(fg_rise)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_phase (
    .clock(clock), .reset(reset), .async_in(phase_signal),
    .level(phase_level_unused), .rise(phase_rise)
  );

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [SHIFT_W-1:0]  shift_reg, shift_next;
  logic [STEP_W-1:0]   step_idx_reg, step_idx_next;
  logic                trigger_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      step_idx_reg <= '0;
      trigger_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      step_idx_reg <= step_idx_next;
      // Registered from the next state so the first high clock lands 1+shift after the edge.
      trigger_reg  <= (state_next == FIRE);
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    step_idx_next = step_idx_reg;
    case (state_reg)
      IDLE: begin
        step_idx_next = '0;
        if (start_sync) state_next = WAIT_FG;
      end
      WAIT_FG: begin
        if (!start_sync) begin
          state_next = IDLE;
        end else if (fg_rise) begin
          state_next = FG_WAIT;
          cnt_next   = '0;
        end
      end
      FG_WAIT: begin
        if (!start_sync) begin
          state_next = IDLE;
        end else if (cnt_reg == FG_LAST) begin
          state_next = WAIT_PH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT_PH: begin
        if (!start_sync) begin
          state_next = IDLE;
        end else if (phase_rise) begin
          state_next = SHIFT;
          cnt_next   = '0;
          shift_next = SHIFT_W'(step_idx_reg) * SHIFT_W'(PHASE_STEP_CYCLES);
        end
      end
      // SHIFT and FIRE deliberately ignore start so a pulse is never cut short.
      SHIFT: begin
        if (cnt_reg == CNT_W'(shift_reg)) begin
          state_next = FIRE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      FIRE: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = NEXT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      NEXT: begin
        step_idx_next = (step_idx_reg == STEP_LAST) ? '0 : step_idx_reg + STEP_W'(1);
        state_next    = start_sync ? WAIT_FG : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign output_trigger = trigger_reg;

endmodule

// File: tb/tb_fsm_calibration.sv
// Directed bench for fsm_calibration: small timing parameters, free-running
// 240-clock phase reference, pulses timed against hand-derived clock numbers.
module tb_fsm_calibration;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_signal = 1'b0;
  logic fg_signal = 1'b0;
  logic phase_signal = 1'b0;
  logic output_trigger;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_rise = 0;
  int n_fall = 0;
  int last_rise = -1;
  int last_width = -1;
  logic prev_trig = 1'b0;

  fsm_calibration #(
    .FG_DELAY_CYCLES(100),
    .PHASE_STEP_CYCLES(8),
    .PHASE_STEPS(4),
    .PULSE_CYCLES(40),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_signal(start_signal),
    .fg_signal(fg_signal),
    .phase_signal(phase_signal),
    .output_trigger(output_trigger)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Phase reference: rising drive on negedges where cyc is a multiple of 240.
  always @(negedge clock) phase_signal = ((cyc % 240) < 120);

  // Pulse monitor: rise clock number and width of each trigger pulse.
  always @(negedge clock) begin
    if (output_trigger === 1'b1 && prev_trig === 1'b0) begin
      n_rise++;
      last_rise = cyc;
    end
    if (output_trigger === 1'b0 && prev_trig === 1'b1) begin
      n_fall++;
      last_width = cyc - last_rise;
    end
    prev_trig = output_trigger;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // fg drive at cyc%240==10; the next phase rise drive is then at f+230, and the
  // trigger follows by 2 sync flops + edge flop + 1 clock, plus the shift.
  function automatic int exp_rise(input int f, input int shift);
    return f + 230 + 4 + shift;
  endfunction

  task automatic fg_pulse(output int f);
    while (cyc % 240 != 10) step();
    f = cyc;
    fg_signal = 1'b1;
    repeat (20) step();
    fg_signal = 1'b0;
  endtask

  task automatic wait_pulse(input int want_rise, input string tag);
    int n0;
    int t;
    n0 = n_fall;
    t = 0;
    while (n_fall == n0 && t < 1200) begin
      step();
      t++;
    end
    check({tag, "_done"}, n_fall - n0, 1);
    check({tag, "_rise"}, last_rise, want_rise);
    check({tag, "_width"}, last_width, 40);
  endtask

  initial begin
    int f;
    int base;
    int n0;
    int t;

    // 1: reset held with inputs toggling
    for (int i = 0; i < 20; i++) begin
      start_signal = 1'($urandom_range(0, 1));
      fg_signal    = 1'($urandom_range(0, 1));
      step();
      check("reset_trig", {31'd0, output_trigger}, 0);
    end
    start_signal = 1'b0;
    fg_signal    = 1'b0;
    reset        = 1'b0;
    repeat (300) step();
    check("idle_no_pulse", n_rise, 0);

    // 2: single shot, step 0
    start_signal = 1'b1;
    repeat (5) step();
    fg_pulse(f);
    wait_pulse(exp_rise(f, 0), "t2");
    start_signal = 1'b0;
    repeat (10) step();
    start_signal = 1'b1;
    repeat (10) step();

    // 3: five shots, shift sweep with wrap
    for (int k = 0; k < 5; k++) begin
      fg_pulse(f);
      wait_pulse(exp_rise(f, (k % 4) * 8), $sformatf("t3_%0d", k));
    end

    // 4: start dropped mid-pulse (step 1, shift 8), then restart at step 0
    fg_pulse(f);
    n0 = n_rise;
    t = 0;
    while (n_rise == n0 && t < 1000) begin
      step();
      t++;
    end
    check("t4_rise_seen", n_rise - n0, 1);
    repeat (5) step();
    start_signal = 1'b0;
    wait_pulse(exp_rise(f, 8), "t4_drop");
    repeat (10) step();
    start_signal = 1'b1;
    repeat (10) step();
    fg_pulse(f);
    wait_pulse(exp_rise(f, 0), "t4_restart");

    // 5: no pulses while disabled; a second fg edge in FG_WAIT is ignored
    start_signal = 1'b0;
    repeat (10) step();
    base = n_rise;
    for (int k = 0; k < 3; k++) fg_pulse(f);
    repeat (300) step();
    check("t5_no_pulse", n_rise - base, 0);
    start_signal = 1'b1;
    repeat (10) step();
    fg_pulse(f);
    repeat (20) step();
    fg_signal = 1'b1;
    repeat (20) step();
    fg_signal = 1'b0;
    base = n_rise;
    wait_pulse(exp_rise(f, 0), "t5_double");
    repeat (500) step();
    check("t5_single", n_rise - base, 1);

    // 6: start dropped in FG_WAIT aborts; restart begins at step 0
    fg_pulse(f);
    repeat (10) step();
    start_signal = 1'b0;
    base = n_rise;
    repeat (500) step();
    check("t6_no_pulse", n_rise - base, 0);
    start_signal = 1'b1;
    repeat (10) step();
    fg_pulse(f);
    wait_pulse(exp_rise(f, 0), "t6_restart");

    check("total_pulses", n_rise, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
